// File: rtl/p2tdm.sv
// Parallel-to-TDM serializer: 8x32-bit words in, sclk/fs/tdmout out.
// One holding buffer in front of a 256-bit shift register; fs marks the last bit of each frame.
module p2tdm #(
  parameter int CLKDIV_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [CLKDIV_W-1:0] clkDiv,
  input  logic                pvalid,
  input  logic [255:0]        pdata,
  output logic                pready,
  output logic                sclk,
  output logic                fs,
  output logic                tdmout,
  output logic                frameStart,
  output logic                underrun,
  output logic [1:0]          state_dbg
);

  // Handshake: a word transfers on any rising clk edge where pvalid && pready.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]          state;
  logic [CLKDIV_W-1:0] div_reg;
  logic [CLKDIV_W-1:0] div_cnt;
  logic [CLKDIV_W-1:0] div_eff;
  logic [7:0]          bit_cnt;
  logic [7:0]          bit_nxt;
  logic [255:0]        shift;
  logic [255:0]        holding;
  logic [255:0]        load_src;
  logic                full;
  logic                div_tc;
  logic                frame_load;
  logic                accept;

  assign div_eff    = (clkDiv == '0) ? CLKDIV_W'(1) : clkDiv;
  assign div_tc     = (div_cnt == div_reg - CLKDIV_W'(1));
  assign frame_load = (state == SYNC) || (bit_cnt == 8'd0);
  assign load_src   = full ? holding : '0;
  assign bit_nxt    = bit_cnt - 8'd1;
  assign pready     = !full;
  assign accept     = pvalid && pready;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      div_reg    <= CLKDIV_W'(1);
      div_cnt    <= '0;
      bit_cnt    <= 8'd255;
      shift      <= '0;
      sclk       <= 1'b0;
      fs         <= 1'b0;
      tdmout     <= 1'b0;
      frameStart <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frameStart <= 1'b0;
      underrun   <= 1'b0;
      if (!enable) begin
        if (state == IDLE) div_reg <= div_eff;
        state   <= IDLE;
        div_cnt <= '0;
        bit_cnt <= 8'd255;
        sclk    <= 1'b0;
        fs      <= 1'b0;
        tdmout  <= 1'b0;
      end else if (state == IDLE) begin
        // Entering SYNC counts as the first launch: the sync slot starts here.
        div_reg <= div_eff;
        state   <= SYNC;
        div_cnt <= '0;
        bit_cnt <= 8'd255;
        sclk    <= 1'b0;
        fs      <= 1'b1;
        tdmout  <= 1'b0;
      end else if (div_tc) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          if (frame_load) begin
            state      <= RUN;
            shift      <= load_src;
            bit_cnt    <= 8'd255;
            fs         <= 1'b0;
            tdmout     <= load_src[255];
            frameStart <= 1'b1;
            underrun   <= !full;
          end else begin
            bit_cnt <= bit_nxt;
            tdmout  <= shift[bit_nxt];
            fs      <= (bit_nxt == 8'd0);
          end
        end
      end else begin
        div_cnt <= div_cnt + CLKDIV_W'(1);
      end
    end
  end

  // A consumed buffer is released one clk after the frameStart pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full    <= 1'b0;
      holding <= '0;
    end else if (state != IDLE && !enable) begin
      full <= 1'b0;
    end else if (accept) begin
      holding <= pdata;
      full    <= 1'b1;
    end else if (frameStart && !underrun) begin
      full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p2tdm.sv
// Bench for p2tdm: a TDM receiver on sclk/fs/tdmout feeds a scoreboard of pushed words.
module tb_p2tdm;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         enable;
  logic [7:0]   clkDiv;
  logic         pvalid;
  logic [255:0] pdata;
  logic         pready;
  logic         sclk;
  logic         fs;
  logic         tdmout;
  logic         frameStart;
  logic         underrun;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];

  int rx_count  = 0;
  int rx_cnt    = 0;
  int und_count = 0;

  always #5 clk = ~clk;

  p2tdm #(.CLKDIV_W(8)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clkDiv(clkDiv),
    .pvalid(pvalid), .pdata(pdata), .pready(pready),
    .sclk(sclk), .fs(fs), .tdmout(tdmout),
    .frameStart(frameStart), .underrun(underrun), .state_dbg(state_dbg)
  );

  // Receiver: samples on sclk rising; fs high marks the slot before CH1 MSB.
  initial begin
    logic         prev_sclk;
    logic         prev_tdm;
    logic [1:0]   prev_state;
    logic         rx_on;
    logic [255:0] rx_acc;
    logic [255:0] word;
    logic [255:0] exp;
    prev_sclk = 1'b0; prev_tdm = 1'b0; prev_state = S_IDLE; rx_on = 1'b0; rx_acc = '0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        rx_on = 1'b0; rx_cnt = 0; prev_sclk = 1'b0; prev_tdm = 1'b0; prev_state = S_IDLE;
      end else begin
        if (underrun === 1'b1) und_count++;
        if (prev_state == S_RUN && state_dbg == S_RUN && tdmout !== prev_tdm) begin
          checks++;
          if (!(prev_sclk === 1'b1 && sclk === 1'b0)) begin
            errors++;
            $display("FAIL tdm_edge: tdmout changed with sclk %b->%b, required 1->0", prev_sclk, sclk);
          end
        end
        if (prev_sclk === 1'b0 && sclk === 1'b1) begin
          if (fs === 1'b1) begin
            if (rx_on && rx_cnt == 255) begin
              word = {rx_acc[254:0], tdmout};
              rx_count++;
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got frame %h, no word expected", word);
              end else begin
                exp = exp_q.pop_front();
                if (word !== exp) begin
                  errors++;
                  $display("FAIL rx_word: got %h, required %h", word, exp);
                end
              end
            end
            rx_on = 1'b1;
            rx_cnt = 0;
          end else if (rx_on) begin
            rx_acc = {rx_acc[254:0], tdmout};
            rx_cnt++;
          end
        end
        prev_sclk = sclk; prev_tdm = tdmout; prev_state = state_dbg;
      end
    end
  end

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic push_word(input logic [255:0] w);
    int n = 0;
    while (pready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (pready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL push_timeout: pready=%b after %0d clks, required 1", pready, n);
    end else begin
      pvalid = 1'b1; pdata = w; exp_q.push_back(w);
      @(negedge clk);
      pvalid = 1'b0;
    end
  endtask

  task automatic wait_rx(input int target, input int limit, input string name);
    int n = 0;
    while (rx_count < target && n < limit) begin @(negedge clk); n++; end
    if (rx_count < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout: received %0d frames, required %0d", name, rx_count, target);
    end
  endtask

  task automatic idle_cleanup();
    enable = 1'b0; pvalid = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; pvalid = 1'b0; pdata = '0; clkDiv = 8'd0;
    #12;
    checks++;
    if ({sclk, fs, tdmout, frameStart, underrun, pready, state_dbg} !== {5'b00000, 1'b1, S_IDLE}) begin
      errors++;
      $display("FAIL reset_state: sclk/fs/tdm/fst/und/pready/state=%b%b%b%b%b%b/%0d, required 000001/0",
               sclk, fs, tdmout, frameStart, underrun, pready, state_dbg);
    end
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (sclk !== 1'b0 || state_dbg !== S_IDLE) begin
        errors++;
        $display("FAIL reset_no_launch: sclk=%b state=%0d with enable=0, required 0/0", sclk, state_dbg);
      end
    end
  endtask

  task automatic test_basic();
    logic [255:0] w;
    logic [4:0] exp_v;
    logic [4:0] got_v;
    int base, fst, und, n;
    w = {32'h80000001, {7{32'hA5A5A5A5}}};
    clkDiv = 8'd2;
    push_word(w);
    checks++;
    if (pready !== 1'b0) begin
      errors++; $display("FAIL basic_pready_full: pready=%b, required 0", pready);
    end
    base = rx_count;
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_v = {1'(((k - 1) / 2) % 2), 1'(k <= 4), 1'(k == 5), 1'(k >= 5 && k <= 8), 1'(k >= 6)};
      got_v = {sclk, fs, frameStart, tdmout, pready};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL basic_timing clk%0d: sclk/fs/fst/tdm/pready=%b, required %b", k, got_v, exp_v);
      end
    end
    fst = 0; und = 0; n = 0;
    while (rx_count < base + 1 && n < 1200) begin
      @(negedge clk); n++;
      if (frameStart === 1'b1) fst++;
      if (underrun === 1'b1) und++;
    end
    if (rx_count < base + 1) begin
      checks++; errors++; $display("FAIL basic_rx_timeout: got %0d frames, required 1", rx_count - base);
    end
    checks++;
    if (fst != 0 || und != 0) begin
      errors++; $display("FAIL basic_pulses: extra frameStart=%0d underrun=%0d, required 0/0", fst, und);
    end
    idle_cleanup();
  endtask

  task automatic test_underrun();
    int base, ones;
    clkDiv = 8'd1;
    base = rx_count;
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({frameStart, underrun} !== {1'(k == 3), 1'(k == 3)}) begin
        errors++;
        $display("FAIL underrun_pulse clk%0d: fst/und=%b%b, required %0d%0d", k, frameStart, underrun, k == 3, k == 3);
      end
    end
    exp_q.push_back('0);
    ones = 0;
    for (int n = 0; n < 600 && rx_count < base + 1; n++) begin
      @(negedge clk);
      if (tdmout === 1'b1) ones++;
    end
    if (rx_count < base + 1) begin
      checks++; errors++; $display("FAIL underrun_rx_timeout: got %0d frames, required 1", rx_count - base);
    end
    checks++;
    if (ones != 0) begin
      errors++; $display("FAIL underrun_tdm: tdmout high %0d clks, required 0", ones);
    end
    idle_cleanup();
  endtask

  task automatic test_loopback();
    logic [255:0] w[3];
    int base, u0, t1, t2, n;
    logic ps;
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    clkDiv = 8'd4;
    base = rx_count;
    u0 = und_count;
    push_word(w[0]);
    enable = 1'b1;
    @(negedge clk);
    clkDiv = 8'd7;
    t1 = -1; t2 = -1; n = 0; ps = sclk;
    while (t2 < 0 && n < 40) begin
      @(negedge clk); n++;
      if (!ps && sclk) begin
        if (t1 < 0) t1 = n; else t2 = n;
      end
      ps = sclk;
    end
    checks++;
    if (t2 - t1 != 8) begin
      errors++; $display("FAIL loop_period: sclk period %0d clks, required 8", t2 - t1);
    end
    push_word(w[1]);
    push_word(w[2]);
    wait_rx(base + 3, 7000, "loopback");
    checks++;
    if (und_count != u0) begin
      errors++; $display("FAIL loop_underrun: %0d underrun pulses, required 0", und_count - u0);
    end
    idle_cleanup();
  endtask

  task automatic test_back_to_back();
    int base, u0, n;
    logic acc_prev, prev_fst, prev_und;
    clkDiv = 8'd0;
    base = rx_count;
    u0 = und_count;
    pvalid = 1'b1;
    pdata = rand_word();
    exp_q.push_back(pdata);
    acc_prev = 1'b1; prev_fst = 1'b0; prev_und = 1'b0;
    enable = 1'b1;
    n = 0;
    while (rx_count < base + 3 && n < 2500) begin
      @(negedge clk); n++;
      if (n <= 3) begin
        checks++;
        if (frameStart !== 1'(n == 3)) begin
          errors++; $display("FAIL b2b_first_load clk%0d: frameStart=%b, required %0d", n, frameStart, n == 3);
        end
      end
      if (acc_prev) pdata = rand_word();
      if (prev_fst && !prev_und) begin
        checks++;
        if (pready !== 1'b1) begin
          errors++; $display("FAIL b2b_pready_rise: pready=%b one clk after frameStart, required 1", pready);
        end
      end
      if (frameStart === 1'b1 && underrun !== 1'b1) begin
        checks++;
        if (pready !== 1'b0) begin
          errors++; $display("FAIL b2b_pready_hold: pready=%b during frameStart, required 0", pready);
        end
      end
      acc_prev = (pready === 1'b1);
      if (acc_prev) exp_q.push_back(pdata);
      prev_fst = (frameStart === 1'b1);
      prev_und = (underrun === 1'b1);
    end
    if (rx_count < base + 3) begin
      checks++; errors++; $display("FAIL b2b_rx_timeout: got %0d frames, required 3", rx_count - base);
    end
    checks++;
    if (und_count != u0) begin
      errors++; $display("FAIL b2b_underrun: %0d underrun pulses, required 0", und_count - u0);
    end
    idle_cleanup();
  endtask

  task automatic test_abandon();
    int n;
    clkDiv = 8'd2;
    push_word(rand_word());
    enable = 1'b1;
    n = 0;
    while (frameStart !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    push_word(rand_word());
    n = 0;
    while (rx_cnt < 156 && n < 1000) begin @(negedge clk); n++; end
    if (rx_cnt < 156) begin
      checks++; errors++; $display("FAIL abandon_timeout: bit count %0d, required 156", rx_cnt);
    end
    checks++;
    if (pready !== 1'b0) begin
      errors++; $display("FAIL abandon_pre_full: pready=%b before drop, required 0", pready);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({sclk, fs, tdmout, frameStart, underrun, pready, state_dbg} !== {5'b00000, 1'b1, S_IDLE}) begin
      errors++;
      $display("FAIL abandon_idle: sclk/fs/tdm/fst/und/pready/state=%b%b%b%b%b%b/%0d, required 000001/0",
               sclk, fs, tdmout, frameStart, underrun, pready, state_dbg);
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({fs, frameStart, underrun} !== {1'(k <= 4), 1'(k == 5), 1'(k == 5)}) begin
        errors++;
        $display("FAIL abandon_restart clk%0d: fs/fst/und=%b%b%b, required %0d%0d%0d",
                 k, fs, frameStart, underrun, k <= 4, k == 5, k == 5);
      end
    end
    idle_cleanup();
  endtask

  task automatic test_async_reset();
    int n;
    clkDiv = 8'd3;
    push_word(rand_word());
    enable = 1'b1;
    n = 0;
    while (frameStart !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    push_word(rand_word());
    n = 0;
    while (!(rx_cnt >= 50 && sclk === 1'b1) && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({sclk, fs, tdmout, frameStart, underrun, pready, state_dbg} !== {5'b00000, 1'b1, S_IDLE}) begin
      errors++;
      $display("FAIL async_reset: sclk/fs/tdm/fst/und/pready/state=%b%b%b%b%b%b/%0d, required 000001/0",
               sclk, fs, tdmout, frameStart, underrun, pready, state_dbg);
    end
    enable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle_cleanup();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_loopback();
    test_back_to_back();
    test_abandon();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
